// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multi-cycle control sequencer for the 8-bit RISC core
// Optional build macro: CTRL_SINGLE_STEP_EN adds a step input that gates every re-entry into FETCH.
module ctrl_seq #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [7:0]     instr,
    input  logic           zero,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic           step,
`endif
    output logic           im_rd,
    output logic           pc_inc,
    output logic           pc_ld,
    output logic           ld_opr,
    output logic           alu_en,
    output logic           rf_we,
    output logic           en_dec,
    output logic           en_WD,
    output logic           sel_DM_rd,
    output logic           sel_DM_wr,
    output logic [OPW-1:0] opcode,
    output logic           halted
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_FETCH2, S_EXEC, S_MEM, S_WB, S_HALT, S_WAIT
    } state_e;

    localparam logic [OPW-1:0] OP_LD  = OPW'(8);
    localparam logic [OPW-1:0] OP_ST  = OPW'(9);
    localparam logic [OPW-1:0] OP_LDI = OPW'(10);
    localparam logic [OPW-1:0] OP_JMP = OPW'(11);
    localparam logic [OPW-1:0] OP_BZ  = OPW'(12);
    localparam logic [OPW-1:0] OP_NOP = OPW'(14);

    state_e         state_q, state_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    state_e         fetch_next;

    logic is_alu, is_ld, is_st, is_ldi, is_jmp, is_bz, is_nop;

    // The operand nibble is consumed by the datapath, not by the sequencer.
    logic unused_instr_lo;
    assign unused_instr_lo = ^instr[7-OPW:0];

    assign is_alu = (opcode_q < OP_LD);
    assign is_ld  = (opcode_q == OP_LD);
    assign is_st  = (opcode_q == OP_ST);
    assign is_ldi = (opcode_q == OP_LDI);
    assign is_jmp = (opcode_q == OP_JMP);
    assign is_bz  = (opcode_q == OP_BZ);
    assign is_nop = (opcode_q == OP_NOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
`ifdef CTRL_SINGLE_STEP_EN
        fetch_next = step ? S_FETCH : S_WAIT;
`else
        fetch_next = S_FETCH;
`endif
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_FETCH;
            S_FETCH: begin
                opcode_d = instr[7 -: OPW];
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                // Anything outside the defined opcode set (0xD, 0xF) halts.
                if (is_alu)                        state_d = S_EXEC;
                else if (is_ld || is_st)           state_d = S_MEM;
                else if (is_ldi || is_jmp || is_bz) state_d = S_FETCH2;
                else if (is_nop)                   state_d = fetch_next;
                else                               state_d = S_HALT;
            end
            S_FETCH2: state_d = is_ldi ? S_WB : fetch_next;
            S_EXEC:   state_d = S_WB;
            S_MEM:    state_d = is_ld ? S_WB : fetch_next;
            S_WB:     state_d = fetch_next;
`ifdef CTRL_SINGLE_STEP_EN
            S_WAIT:   if (step) state_d = S_FETCH;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        im_rd     = 1'b0;
        pc_inc    = 1'b0;
        pc_ld     = 1'b0;
        ld_opr    = 1'b0;
        alu_en    = 1'b0;
        rf_we     = 1'b0;
        en_dec    = 1'b0;
        en_WD     = 1'b0;
        sel_DM_rd = 1'b0;
        sel_DM_wr = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                im_rd  = 1'b1;
                pc_inc = 1'b1;
            end
            S_DECODE: en_dec = is_ld;
            S_FETCH2: begin
                im_rd = 1'b1;
                if (is_ldi) begin
                    ld_opr = 1'b1;
                    pc_inc = 1'b1;
                end else if (is_jmp) begin
                    pc_ld = 1'b1;
                end else if (is_bz) begin
                    pc_ld  = zero;
                    pc_inc = ~zero;
                end
            end
            S_EXEC: alu_en = 1'b1;
            S_MEM: begin
                sel_DM_rd = is_ld;
                sel_DM_wr = is_st;
                en_WD     = is_st;
            end
            S_WB:    rf_we  = 1'b1;
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign opcode = opcode_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - self-checking bench for ctrl_seq
module tb_ctrl_seq;

    logic       clk, rst_n, start, zero;
    logic [7:0] instr;
    logic       im_rd, pc_inc, pc_ld, ld_opr, alu_en, rf_we, en_dec, en_WD;
    logic       sel_DM_rd, sel_DM_wr, halted;
    logic [3:0] opcode;

    ctrl_seq #(.OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .zero(zero),
        .im_rd(im_rd), .pc_inc(pc_inc), .pc_ld(pc_ld), .ld_opr(ld_opr),
        .alu_en(alu_en), .rf_we(rf_we), .en_dec(en_dec), .en_WD(en_WD),
        .sel_DM_rd(sel_DM_rd), .sel_DM_wr(sel_DM_wr), .opcode(opcode),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector bit order: im_rd pc_inc pc_ld ld_opr alu_en rf_we en_dec en_WD rd wr halted
    localparam logic [10:0] V_IM  = 11'b100_0000_0000;
    localparam logic [10:0] V_INC = 11'b010_0000_0000;
    localparam logic [10:0] V_PLD = 11'b001_0000_0000;
    localparam logic [10:0] V_OPR = 11'b000_1000_0000;
    localparam logic [10:0] V_ALU = 11'b000_0100_0000;
    localparam logic [10:0] V_WE  = 11'b000_0010_0000;
    localparam logic [10:0] V_DEC = 11'b000_0001_0000;
    localparam logic [10:0] V_WD  = 11'b000_0000_1000;
    localparam logic [10:0] V_RD  = 11'b000_0000_0100;
    localparam logic [10:0] V_WR  = 11'b000_0000_0010;
    localparam logic [10:0] V_HLT = 11'b000_0000_0001;

    logic [10:0] dut_vec;
    assign dut_vec = {im_rd, pc_inc, pc_ld, ld_opr, alu_en, rf_we, en_dec,
                      en_WD, sel_DM_rd, sel_DM_wr, halted};

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Instruction-level model: cycles per instruction and the strobe set of each cycle.
    function automatic int cpi(input logic [3:0] op);
        if (op == 4'hE || op == 4'hD || op == 4'hF) return 2;
        if (op == 4'h9 || op == 4'hB || op == 4'hC) return 3;
        return 4;
    endfunction

    function automatic logic [10:0] exp_out(input logic [3:0] op, input int k, input logic z);
        case (k)
            0: return V_IM | V_INC;
            1: return (op == 4'h8) ? V_DEC : 11'd0;
            2: begin
                if (op <= 4'h7) return V_ALU;
                case (op)
                    4'h8: return V_RD;
                    4'h9: return V_WR | V_WD;
                    4'hA: return V_IM | V_OPR | V_INC;
                    4'hB: return V_IM | V_PLD;
                    4'hC: return V_IM | (z ? V_PLD : V_INC);
                    default: return 11'd0;
                endcase
            end
            3: return V_WE;
            default: return 11'd0;
        endcase
    endfunction

    logic        exp_valid = 1'b0;
    logic [10:0] exp_vec = '0;
    logic [3:0]  exp_op = '0;
    string       exp_tag = "";
    logic [3:0]  prev_op = 4'h0;
    int n_alu = 0, n_we = 0, n_rd = 0, n_wr = 0, n_wd = 0, n_dec = 0;

    always @(negedge clk) begin
        if (exp_valid) begin
            check({exp_tag, "_out"}, 32'(dut_vec), 32'(exp_vec));
            check({exp_tag, "_opcode"}, 32'(opcode), 32'(exp_op));
        end
        check("excl_pc", 32'(pc_inc & pc_ld), 32'd0);
        check("excl_dm", 32'(sel_DM_rd & sel_DM_wr), 32'd0);
        n_alu += int'(alu_en);
        n_we  += int'(rf_we);
        n_rd  += int'(sel_DM_rd);
        n_wr  += int'(sel_DM_wr);
        n_wd  += int'(en_WD);
        n_dec += int'(en_dec);
    end

    // Drives one instruction cycle by cycle; stop_k >= 0 returns mid-cycle stop_k.
    task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1, input logic z,
                             input int stop_k);
        logic [3:0] op;
        int n;
        op = b0[7:4];
        n = cpi(op);
        for (int k = 0; k < n; k++) begin
            if (k == 0) instr = b0;
            else if (k == 2 && (op == 4'hA || op == 4'hB || op == 4'hC)) instr = b1;
            else instr = 8'($urandom);
            zero  = (k == 2 && op == 4'hC) ? z : 1'($urandom);
            start = 1'($urandom);
            exp_vec   = exp_out(op, k, z);
            exp_op    = (k == 0) ? prev_op : op;
            exp_tag   = $sformatf("i%02h_z%0d_c%0d", b0, z, k);
            exp_valid = 1'b1;
            if (k == stop_k) return;
            @(posedge clk); #1;
        end
        prev_op = op;
    endtask

    task automatic halt_and_restart(input logic [3:0] op);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_vec = V_HLT; exp_op = op; exp_tag = "halt_hold";
            @(posedge clk); #1;
        end
        start = 1'b1;
        exp_vec = V_HLT; exp_tag = "halt_start";
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_im_rd", 32'(im_rd), 32'd1);
        check("restart_halted", 32'(halted), 32'd0);
    endtask

    int a0, w0, r0, d0, x0, e0;

    initial begin
        rst_n = 1'b0; start = 1'b0; zero = 1'b0; instr = 8'h00;

        check("cpi_nop", 32'(cpi(4'hE)), 32'd2);
        check("cpi_alu", 32'(cpi(4'h1)), 32'd4);
        check("cpi_ld",  32'(cpi(4'h8)), 32'd4);
        check("cpi_st",  32'(cpi(4'h9)), 32'd3);
        check("cpi_bz",  32'(cpi(4'hC)), 32'd3);
        check("cpi_ldi", 32'(cpi(4'hA)), 32'd4);
        check("exp_bz1", 32'(exp_out(4'hC, 2, 1'b1)), 32'(V_IM | V_PLD));

        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(dut_vec), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        exp_vec = '0; exp_op = 4'h0; exp_tag = "idle"; exp_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;

        a0 = n_alu; w0 = n_we; r0 = n_rd; d0 = n_dec;
        run_instr(8'hE0, 8'h00, 1'b0, -1);
        run_instr(8'h12, 8'h00, 1'b0, -1);
        run_instr(8'h85, 8'h00, 1'b0, -1);
        check("seq_alu_cnt", 32'(n_alu - a0), 32'd1);
        check("seq_we_cnt",  32'(n_we - w0),  32'd2);
        check("seq_rd_cnt",  32'(n_rd - r0),  32'd1);
        check("seq_dec_cnt", 32'(n_dec - d0), 32'd1);

        w0 = n_wr; x0 = n_wd; r0 = n_rd;
        run_instr(8'h96, 8'h00, 1'b0, -1);
        check("st_wr_cnt", 32'(n_wr - w0), 32'd1);
        check("st_wd_cnt", 32'(n_wd - x0), 32'd1);
        check("st_rd_cnt", 32'(n_rd - r0), 32'd0);

        run_instr(8'hC0, 8'h20, 1'b1, -1);
        run_instr(8'hC0, 8'h20, 1'b0, -1);
        e0 = n_we;
        run_instr(8'hA1, 8'h7F, 1'b0, -1);
        check("ldi_we_cnt", 32'(n_we - e0), 32'd1);
        run_instr(8'hB0, 8'h10, 1'b0, -1);
        run_instr(8'h47, 8'h00, 1'b0, -1);

        run_instr(8'hF0, 8'h00, 1'b0, -1);
        halt_and_restart(4'hF);
        run_instr(8'hE0, 8'h00, 1'b0, -1);
        run_instr(8'hD0, 8'h00, 1'b0, -1);
        halt_and_restart(4'hD);

        run_instr(8'h35, 8'h00, 1'b0, 2);
        #1;
        check("exec_alu_en", 32'(alu_en), 32'd1);
        rst_n = 1'b0;
        exp_vec = '0; exp_op = 4'h0; exp_tag = "mid_rst";
        #1;
        check("async_rst_out", 32'(dut_vec), 32'd0);
        check("async_rst_opcode", 32'(opcode), 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_tag = "post_rst_idle";
        repeat (3) begin
            @(posedge clk); #1;
        end
        exp_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
